// File: rtl/tmp_commit_unit_pkg.sv
// Shared definitions for the temp-file commit unit: entry field layout,
// instruction type codes and retirement state encoding.
package tmp_commit_unit_pkg;

    localparam int TC_DEPTH  = 32;
    localparam int TC_ADDR_W = 5;
    localparam int TC_DATA_W = 32;
    localparam int ENTRY_W   = 73;

    localparam int RD_MSB     = 72;
    localparam int RD_LSB     = 68;
    localparam int PC_MSB     = 67;
    localparam int PC_LSB     = 36;
    localparam int TYPE_MSB   = 35;
    localparam int TYPE_LSB   = 34;
    localparam int SDATA_MSB  = 33;
    localparam int SDATA_LSB  = 2;
    localparam int SVALID_BIT = 1;
    localparam int VALID_BIT  = 0;

    typedef enum logic [1:0] {
        REGWR   = 2'b00,
        STORE   = 2'b01,
        BR_OK   = 2'b10,
        BR_MISS = 2'b11
    } inst_type_e;

    typedef enum logic [1:0] {
        CHECK      = 2'b00,
        STORE_WAIT = 2'b01,
        FLUSH      = 2'b10
    } state_e;

endpackage

// File: rtl/tmp_commit_unit_head.sv
// Circular head pointer over the temp entries: advance with wrap, or clear to 0.
module tmp_commit_head #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] head
);

    // Head register; clear has priority over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
        end else if (clr) begin
            head <= '0;
        end else if (inc) begin
            head <= (head == ADDR_W'(DEPTH - 1)) ? '0 : head + ADDR_W'(1);
        end else begin
            head <= head;
        end
    end

endmodule

// File: rtl/tmp_commit_unit.sv
// In-order retirement of temp-file entries into the architectural register
// file, the store path, or a mispredict flush.
module tmp_commit_unit
    import tmp_commit_unit_pkg::*;
#(
    parameter int DEPTH  = TC_DEPTH,
    parameter int ADDR_W = TC_ADDR_W,
    parameter int DATA_W = TC_DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  Rd_Addr,
    input  logic [ENTRY_W-1:0] Data_In,
    input  logic               Commit_en,
    output logic               Free_entry,
    output logic [ADDR_W-1:0]  Free_addr,
    output logic               Arf_we,
    output logic [4:0]         Arf_addr,
    output logic [DATA_W-1:0]  Arf_data,
    output logic               Store_req,
    output logic [DATA_W-1:0]  Store_pc,
    output logic [DATA_W-1:0]  Store_data,
    input  logic               Store_ack,
    output logic               Flush,
    output logic [DATA_W-1:0]  Redirect_pc,
    output logic [31:0]        Retired_count
);

    state_e              state_r, state_next_s;
    logic [ADDR_W-1:0]   head_s;
    logic                inc_s, clr_s, ready_s;
    inst_type_e          type_s;
    logic [4:0]          rd_s;
    logic [DATA_W-1:0]   pc_s, sdata_s;

    logic                free_next_s, arf_we_next_s, store_req_next_s, flush_next_s;
    logic [ADDR_W-1:0]   free_addr_next_s;
    logic [4:0]          arf_addr_next_s;
    logic [DATA_W-1:0]   arf_data_next_s, store_pc_next_s, store_data_next_s, redirect_next_s;

    assign rd_s    = Data_In[RD_MSB:RD_LSB];
    assign pc_s    = Data_In[PC_MSB:PC_LSB];
    assign type_s  = inst_type_e'(Data_In[TYPE_MSB:TYPE_LSB]);
    assign sdata_s = Data_In[SDATA_MSB:SDATA_LSB];
    assign ready_s = Commit_en & Data_In[VALID_BIT] & Data_In[SVALID_BIT];
    assign Rd_Addr = head_s;

    tmp_commit_head #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_head (
        .clock (clock),
        .reset (reset),
        .inc   (inc_s),
        .clr   (clr_s),
        .head  (head_s)
    );

    // Retirement state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= CHECK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, head control and next values of every registered output.
    always_comb begin
        state_next_s      = state_r;
        inc_s             = 1'b0;
        clr_s             = 1'b0;
        free_next_s       = 1'b0;
        free_addr_next_s  = Free_addr;
        arf_we_next_s     = 1'b0;
        arf_addr_next_s   = Arf_addr;
        arf_data_next_s   = Arf_data;
        store_req_next_s  = Store_req;
        store_pc_next_s   = Store_pc;
        store_data_next_s = Store_data;
        flush_next_s      = 1'b0;
        redirect_next_s   = Redirect_pc;
        case (state_r)
            CHECK: begin
                if (ready_s) begin
                    case (type_s)
                        REGWR: begin
                            arf_we_next_s    = (rd_s != 5'd0);
                            arf_addr_next_s  = rd_s;
                            arf_data_next_s  = sdata_s;
                            free_next_s      = 1'b1;
                            free_addr_next_s = head_s;
                            inc_s            = 1'b1;
                        end
                        BR_OK: begin
                            free_next_s      = 1'b1;
                            free_addr_next_s = head_s;
                            inc_s            = 1'b1;
                        end
                        STORE: begin
                            store_req_next_s  = 1'b1;
                            store_pc_next_s   = pc_s;
                            store_data_next_s = sdata_s;
                            state_next_s      = STORE_WAIT;
                        end
                        BR_MISS: begin
                            flush_next_s     = 1'b1;
                            redirect_next_s  = sdata_s;
                            free_next_s      = 1'b1;
                            free_addr_next_s = head_s;
                            state_next_s     = FLUSH;
                        end
                        default: begin
                            state_next_s = CHECK;
                        end
                    endcase
                end else begin
                    state_next_s = CHECK;
                end
            end
            STORE_WAIT: begin
                // Commit_en is deliberately ignored: an issued store always completes.
                if (Store_req && Store_ack) begin
                    store_req_next_s = 1'b0;
                    free_next_s      = 1'b1;
                    free_addr_next_s = head_s;
                    inc_s            = 1'b1;
                    state_next_s     = CHECK;
                end else begin
                    state_next_s = STORE_WAIT;
                end
            end
            FLUSH: begin
                clr_s        = 1'b1;
                state_next_s = CHECK;
            end
            default: begin
                state_next_s = CHECK;
            end
        endcase
    end

    // Registered outputs and retirement counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Free_entry    <= 1'b0;
            Free_addr     <= '0;
            Arf_we        <= 1'b0;
            Arf_addr      <= 5'd0;
            Arf_data      <= '0;
            Store_req     <= 1'b0;
            Store_pc      <= '0;
            Store_data    <= '0;
            Flush         <= 1'b0;
            Redirect_pc   <= '0;
            Retired_count <= 32'd0;
        end else begin
            Free_entry    <= free_next_s;
            Free_addr     <= free_addr_next_s;
            Arf_we        <= arf_we_next_s;
            Arf_addr      <= arf_addr_next_s;
            Arf_data      <= arf_data_next_s;
            Store_req     <= store_req_next_s;
            Store_pc      <= store_pc_next_s;
            Store_data    <= store_data_next_s;
            Flush         <= flush_next_s;
            Redirect_pc   <= redirect_next_s;
            Retired_count <= Retired_count + {31'd0, free_next_s};
        end
    end

endmodule

// File: tb/tb_tmp_commit_unit.sv
// Directed bench for tmp_commit_unit with a behavioural temp file and a
// scoreboard of expected commit events.
module tb_tmp_commit_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  Rd_Addr;
    logic [72:0] Data_In;
    logic        Commit_en;
    logic        Free_entry;
    logic [4:0]  Free_addr;
    logic        Arf_we;
    logic [4:0]  Arf_addr;
    logic [31:0] Arf_data;
    logic        Store_req;
    logic [31:0] Store_pc;
    logic [31:0] Store_data;
    logic        Store_ack;
    logic        Flush;
    logic [31:0] Redirect_pc;
    logic [31:0] Retired_count;

    typedef struct packed {
        logic        free;
        logic [4:0]  faddr;
        logic        we;
        logic [4:0]  aaddr;
        logic [31:0] adata;
        logic        flush;
        logic [31:0] rpc;
    } ev_t;

    logic [72:0] mem [32];
    ev_t         exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    assign Data_In = mem[Rd_Addr];

    always #5 clock = ~clock;

    tmp_commit_unit dut (
        .clock         (clock),
        .reset         (reset),
        .Rd_Addr       (Rd_Addr),
        .Data_In       (Data_In),
        .Commit_en     (Commit_en),
        .Free_entry    (Free_entry),
        .Free_addr     (Free_addr),
        .Arf_we        (Arf_we),
        .Arf_addr      (Arf_addr),
        .Arf_data      (Arf_data),
        .Store_req     (Store_req),
        .Store_pc      (Store_pc),
        .Store_data    (Store_data),
        .Store_ack     (Store_ack),
        .Flush         (Flush),
        .Redirect_pc   (Redirect_pc),
        .Retired_count (Retired_count)
    );

    function automatic logic [72:0] mk(input logic [4:0] rd, input logic [31:0] pc,
                                       input logic [1:0] typ, input logic [31:0] sd,
                                       input logic sv, input logic v);
        return {rd, pc, typ, sd, sv, v};
    endfunction

    function automatic ev_t ev_reg(input logic [4:0] a, input logic [4:0] rd, input logic [31:0] d);
        ev_t e;
        e = '0;
        e.free = 1'b1; e.faddr = a; e.we = (rd != 5'd0); e.aaddr = rd; e.adata = d;
        return e;
    endfunction

    function automatic ev_t ev_free(input logic [4:0] a);
        ev_t e;
        e = '0;
        e.free = 1'b1; e.faddr = a;
        return e;
    endfunction

    function automatic ev_t ev_miss(input logic [4:0] a, input logic [31:0] rpc);
        ev_t e;
        e = '0;
        e.free = 1'b1; e.faddr = a; e.flush = 1'b1; e.rpc = rpc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare any strobe activity against the head of the scoreboard.
    task automatic mon();
        ev_t e;
        if (Free_entry || Arf_we || Flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, Free_entry, Arf_we, Flush}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("free_entry", 32'(Free_entry), 32'(e.free));
                chk("arf_we", 32'(Arf_we), 32'(e.we));
                chk("flush", 32'(Flush), 32'(e.flush));
                if (e.free) chk("free_addr", 32'(Free_addr), 32'(e.faddr));
                if (e.we) begin
                    chk("arf_addr", 32'(Arf_addr), 32'(e.aaddr));
                    chk("arf_data", Arf_data, e.adata);
                end
                if (e.flush) chk("redirect_pc", Redirect_pc, e.rpc);
            end
        end
    endtask

    // One clock: sample after the edge, then emulate the temp file's clears.
    task automatic tick();
        @(posedge clock);
        #1;
        mon();
        if (Free_entry) mem[Free_addr][0] = 1'b0;
        if (Flush) for (int i = 0; i < 32; i++) mem[i][0] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset = 1'b1; Commit_en = 1'b0; Store_ack = 1'b0;
        tick(); tick();
        chk("rst_rd_addr", 32'(Rd_Addr), 32'd0);
        chk("rst_retired", Retired_count, 32'd0);
        chk("rst_strobes", {28'd0, Free_entry, Arf_we, Store_req, Flush}, 32'd0);
        chk("rst_arf_data", Arf_data, 32'd0);
        chk("rst_redirect", Redirect_pc, 32'd0);
        reset = 1'b0;
        tick();

        // REGWR at entry 0
        mem[0] = mk(5'd5, 32'h0, 2'b00, 32'hDEADBEEF, 1'b1, 1'b1);
        Commit_en = 1'b1;
        exp_q.push_back(ev_reg(5'd0, 5'd5, 32'hDEADBEEF));
        tick();
        chk("t1_rd_addr", 32'(Rd_Addr), 32'd1);
        chk("t1_retired", Retired_count, 32'd1);

        // BR_OK at entry 1
        mem[1] = mk(5'd0, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1);
        exp_q.push_back(ev_free(5'd1));
        tick();
        chk("brok_rd_addr", 32'(Rd_Addr), 32'd2);

        // STORE at entry 2, held 4 cycles, Commit_en dropped mid-wait
        mem[2] = mk(5'd0, 32'h400, 2'b01, 32'h55, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 1) Commit_en = 1'b0;
            chk("st_req", 32'(Store_req), 32'd1);
            chk("st_pc", Store_pc, 32'h400);
            chk("st_data", Store_data, 32'h55);
            chk("st_rd_addr", 32'(Rd_Addr), 32'd2);
        end
        Store_ack = 1'b1;
        exp_q.push_back(ev_free(5'd2));
        tick();
        Store_ack = 1'b0;
        Commit_en = 1'b1;
        chk("st_req_drop", 32'(Store_req), 32'd0);
        chk("st_rd_addr_post", 32'(Rd_Addr), 32'd3);
        chk("st_retired", Retired_count, 32'd3);

        // Entry 3 valid but not spec_valid: stall 10 cycles
        mem[3] = mk(5'd9, 32'h0, 2'b00, 32'h1234, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall_strobes", {30'd0, Free_entry, Arf_we}, 32'd0);
        end
        chk("stall_rd_addr", 32'(Rd_Addr), 32'd3);
        mem[3][1] = 1'b1;
        exp_q.push_back(ev_reg(5'd3, 5'd9, 32'h1234));
        tick();
        chk("stall_commit", 32'(Free_entry), 32'd1);
        chk("stall_retired", Retired_count, 32'd4);

        // REGWR to r0: freed and counted, no write
        mem[4] = mk(5'd0, 32'h0, 2'b00, 32'hCAFE, 1'b1, 1'b1);
        exp_q.push_back(ev_reg(5'd4, 5'd0, 32'hCAFE));
        tick();
        chk("r0_retired", Retired_count, 32'd5);

        // BR_OK, BR_OK, then BR_MISS at entry 7
        mem[5] = mk(5'd0, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1);
        mem[6] = mk(5'd0, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1);
        mem[7] = mk(5'd0, 32'h0, 2'b11, 32'h1000, 1'b1, 1'b1);
        mem[8] = mk(5'd1, 32'h0, 2'b00, 32'h8, 1'b1, 1'b1);
        exp_q.push_back(ev_free(5'd5));
        exp_q.push_back(ev_free(5'd6));
        exp_q.push_back(ev_miss(5'd7, 32'h1000));
        tick(); tick(); tick();
        chk("miss_flush", 32'(Flush), 32'd1);
        chk("miss_retired", Retired_count, 32'd8);
        tick();
        chk("miss_flush_pulse", 32'(Flush), 32'd0);
        chk("miss_rd_addr", 32'(Rd_Addr), 32'd0);

        // Fresh reset, then 33 back-to-back REGWR commits with wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++)
            mem[i] = mk(5'((i % 31) + 1), 32'h0, 2'b00, 32'h1000_0000 + 32'(i), 1'b1, 1'b1);
        for (int k = 0; k < 33; k++) begin
            exp_q.push_back(ev_reg(5'(k % 32), 5'(((k % 32) % 31) + 1), 32'h1000_0000 + 32'(k)));
            tick();
            if (k == 0) mem[0] = mk(5'd1, 32'h0, 2'b00, 32'h1000_0020, 1'b1, 1'b1);
            chk("b2b_rd_addr", 32'(Rd_Addr), 32'((k + 1) % 32));
        end
        chk("b2b_retired", Retired_count, 32'd33);

        // Reset while a store is outstanding
        mem[1] = mk(5'd0, 32'h800, 2'b01, 32'h77, 1'b1, 1'b1);
        tick();
        chk("rs_req_up", 32'(Store_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rs_req_drop", 32'(Store_req), 32'd0);
        chk("rs_rd_addr", 32'(Rd_Addr), 32'd0);
        chk("rs_retired", Retired_count, 32'd0);
        for (int i = 0; i < 32; i++) mem[i] = '0;
        tick();
        chk("rs_req_hold", 32'(Store_req), 32'd0);
        reset = 1'b0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
